// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - state encoding, width helper and timeout fill byte for the CPU bus master
package cpu_bus_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_WR      = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    // Index width that never collapses to zero bits
    function automatic int lw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cpu_bus_rr_arbiter.sv
// rtl/cpu_bus_rr_arbiter.sv - combinational round-robin pick, lowest index strictly after the last winner
module cpu_bus_rr_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IW     = lw_of(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] mask,
    input  logic [IW-1:0]     last,
    output logic [NUM_CH-1:0] gnt,
    output logic [IW-1:0]     gnt_idx,
    output logic              gnt_valid
);

    int cand;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = (int'(last) + i) % NUM_CH;
            if (!gnt_valid && req[cand] && !mask[cand]) begin
                gnt_valid = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/cpu_bus_unit.sv
// rtl/cpu_bus_unit.sv - multi-channel round-robin byte bus master; CPU_BUS_TIMEOUT_EN adds an rd_ack watchdog
module cpu_bus_unit
    import cpu_bus_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int MAX_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CH-1:0]                     ch_req,
    input  logic [NUM_CH-1:0]                     ch_we,
    input  logic [NUM_CH*lw_of(MAX_BYTES)-1:0]    ch_len,
    input  logic [NUM_CH*ADDR_W-1:0]              ch_addr,
    input  logic [NUM_CH*MAX_BYTES*DATA_W-1:0]    ch_wdata,
    output logic [NUM_CH-1:0]                     ch_ack,
    output logic [NUM_CH-1:0]                     ch_err,
    output logic [MAX_BYTES*DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]                     bus_addr,
    output logic                                  rd_req,
    input  logic                                  rd_ack,
    input  logic [DATA_W-1:0]                     rd_data,
    output logic [DATA_W-1:0]                     wr_data,
    output logic                                  wr_enable
);

    localparam int LW = lw_of(MAX_BYTES);
    localparam int IW = lw_of(NUM_CH);
    localparam int WB = MAX_BYTES * DATA_W;

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, gch_q, gch_d;
    logic [LW-1:0]     len_q, len_d, byte_idx_q, byte_idx_d;
    logic [WB-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              rd_req_q, rd_req_d, wr_enable_q, wr_enable_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;

    logic [NUM_CH-1:0] gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [LW-1:0]     sel_len_raw, sel_len;
    logic [WB-1:0]     sel_wdata;
    logic              sel_we;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CH-1:0] ch_err_q, ch_err_d;
    assign ch_err = ch_err_q;
`else
    assign ch_err = '0;
`endif

    // The acked channel is masked; grants only happen in IDLE, where ch_ack_q is already clear
    cpu_bus_rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
        .req       (ch_req),
        .mask      (ch_ack_q),
        .last      (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign sel_addr    = ch_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    assign sel_len_raw = ch_len[int'(gnt_idx)*LW +: LW];
    assign sel_len     = (sel_len_raw > LW'(MAX_BYTES - 1)) ? LW'(MAX_BYTES - 1) : sel_len_raw;
    assign sel_wdata   = ch_wdata[int'(gnt_idx)*WB +: WB];
    assign sel_we      = |(ch_we & gnt);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gch_d       = gch_q;
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        bus_addr_d  = bus_addr_q;
        rd_req_d    = rd_req_q;
        wr_enable_d = wr_enable_q;
        wr_data_d   = wr_data_q;
        ch_ack_d    = '0;
`ifdef CPU_BUS_TIMEOUT_EN
        ch_err_d    = '0;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid && (state_q == ST_IDLE)) begin
                    ptr_d      = gnt_idx;
                    gch_d      = gnt_idx;
                    len_d      = sel_len;
                    wdata_d    = sel_wdata;
                    byte_idx_d = '0;
                    rdata_d    = '0;
                    bus_addr_d = sel_addr;
`ifdef CPU_BUS_TIMEOUT_EN
                    tmo_cnt_d  = '0;
`endif
                    if (sel_we) begin
                        wr_enable_d = 1'b1;
                        wr_data_d   = sel_wdata[DATA_W-1:0];
                        state_d     = ST_WR;
                    end else begin
                        rd_req_d = 1'b1;
                        state_d  = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (rd_ack) begin
                    rdata_d[int'(byte_idx_q)*DATA_W +: DATA_W] = rd_data;
`ifdef CPU_BUS_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    if (byte_idx_q == len_q) begin
                        rd_req_d        = 1'b0;
                        ch_ack_d[gch_q] = 1'b1;
                        state_d         = ST_DONE;
                    end else begin
                        bus_addr_d = bus_addr_q + 1'b1;
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end
`ifdef CPU_BUS_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    for (int b = 0; b < MAX_BYTES; b++) begin
                        if (b >= int'(byte_idx_q) && b <= int'(len_q))
                            rdata_d[b*DATA_W +: DATA_W] = DATA_W'(TIMEOUT_FILL);
                    end
                    rd_req_d        = 1'b0;
                    ch_ack_d[gch_q] = 1'b1;
                    ch_err_d[gch_q] = 1'b1;
                    state_d         = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_WR: begin
                if (byte_idx_q == len_q) begin
                    wr_enable_d     = 1'b0;
                    ch_ack_d[gch_q] = 1'b1;
                    state_d         = ST_DONE;
                end else begin
                    bus_addr_d = bus_addr_q + 1'b1;
                    byte_idx_d = byte_idx_q + 1'b1;
                    wr_data_d  = wdata_q[(int'(byte_idx_q) + 1)*DATA_W +: DATA_W];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IW'(NUM_CH - 1);
            gch_q       <= '0;
            len_q       <= '0;
            byte_idx_q  <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            bus_addr_q  <= '0;
            rd_req_q    <= 1'b0;
            wr_enable_q <= 1'b0;
            wr_data_q   <= '0;
            ch_ack_q    <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            ch_err_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gch_q       <= gch_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            bus_addr_q  <= bus_addr_d;
            rd_req_q    <= rd_req_d;
            wr_enable_q <= wr_enable_d;
            wr_data_q   <= wr_data_d;
            ch_ack_q    <= ch_ack_d;
`ifdef CPU_BUS_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            ch_err_q    <= ch_err_d;
`endif
        end
    end

    assign ch_ack    = ch_ack_q;
    assign rdata     = rdata_q;
    assign bus_addr  = bus_addr_q;
    assign rd_req    = rd_req_q;
    assign wr_data   = wr_data_q;
    assign wr_enable = wr_enable_q;

endmodule

// File: tb/tb_cpu_bus_unit.sv
// tb/tb_cpu_bus_unit.sv - randomized scoreboard bench for cpu_bus_unit
module tb_cpu_bus_unit;

    localparam int NUM_CH    = 2;
    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int MAX_BYTES = 2;
    localparam int LW        = 1;
    localparam int WB        = MAX_BYTES * DATA_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        ch_req, ch_we;
    logic [NUM_CH*LW-1:0]     ch_len;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*WB-1:0]     ch_wdata;
    logic [NUM_CH-1:0]        ch_ack, ch_err;
    logic [WB-1:0]            rdata;
    logic [ADDR_W-1:0]        bus_addr;
    logic                     rd_req, rd_ack, wr_enable;
    logic [DATA_W-1:0]        rd_data, wr_data;

    typedef struct {
        bit            we;
        int            len;
        int            addr;
        logic [WB-1:0] wdata;
    } txn_t;

    txn_t       exp_q [NUM_CH][$];
    logic [7:0] rom [0:65535];
    int         cap_rd_addr [$];
    int         cap_wr_addr [$];
    logic [7:0] cap_wr_data [$];
    int         ack_log [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         mem_en  = 1'b0;
    bit         fast_ack = 1'b0;

    cpu_bus_unit #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_BYTES(MAX_BYTES), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_len(ch_len),
        .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_ack(ch_ack), .ch_err(ch_err),
        .rdata(rdata), .bus_addr(bus_addr), .rd_req(rd_req), .rd_ack(rd_ack),
        .rd_data(rd_data), .wr_data(wr_data), .wr_enable(wr_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory: reads come from rom, one byte per rd_ack, at a random pace unless fast_ack
    initial begin
        rd_ack  = 1'b0;
        rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en && rd_req && !reset && (fast_ack || $urandom_range(0, 2) != 0)) begin
                rd_ack  = 1'b1;
                rd_data = rom[bus_addr];
            end else begin
                rd_ack  = 1'b0;
                rd_data = 8'($urandom);
            end
        end
    end

    task automatic score_ack();
        int            c;
        int            eff;
        txn_t          t;
        logic [WB-1:0] er;
        check("ack_onehot", $countones(ch_ack), 1);
        check("err_low", ch_err, 0);
        check("rd_req_low_at_ack", rd_req, 0);
        check("wr_en_low_at_ack", wr_enable, 0);
        c = 0;
        for (int i = 0; i < NUM_CH; i++) if (ch_ack[i]) c = i;
        ack_log.push_back(c);
        if (exp_q[c].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack ch%0d: got an ack, expected none", c);
        end else begin
            t   = exp_q[c].pop_front();
            eff = (t.len > MAX_BYTES - 1) ? MAX_BYTES - 1 : t.len;
            if (t.we) begin
                check("wr_beats", cap_wr_addr.size(), eff + 1);
                check("wr_no_rd_beats", cap_rd_addr.size(), 0);
                for (int i = 0; i <= eff && i < cap_wr_addr.size(); i++) begin
                    check("wr_addr", cap_wr_addr[i], (t.addr + i) % 65536);
                    check("wr_byte", cap_wr_data[i], (t.wdata >> (8 * i)) & 8'hFF);
                end
            end else begin
                er = '0;
                for (int i = 0; i <= eff; i++)
                    er = er | (WB'(rom[(t.addr + i) % 65536]) << (8 * i));
                check("rd_beats", cap_rd_addr.size(), eff + 1);
                check("rd_no_wr_beats", cap_wr_addr.size(), 0);
                for (int i = 0; i <= eff && i < cap_rd_addr.size(); i++)
                    check("rd_addr", cap_rd_addr[i], (t.addr + i) % 65536);
                check("rdata", rdata, er);
            end
        end
        cap_rd_addr.delete();
        cap_wr_addr.delete();
        cap_wr_data.delete();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                cap_rd_addr.delete();
                cap_wr_addr.delete();
                cap_wr_data.delete();
            end else begin
                if (rd_req && rd_ack) cap_rd_addr.push_back(int'(bus_addr));
                if (wr_enable) begin
                    cap_wr_addr.push_back(int'(bus_addr));
                    cap_wr_data.push_back(wr_data);
                end
                if (ch_ack != '0) score_ack();
            end
        end
    end

    task automatic set_fields(input int c, input bit we, input int len, input int addr,
                              input logic [WB-1:0] wd, input int n);
        txn_t t;
        t.we = we; t.len = len; t.addr = addr; t.wdata = wd;
        ch_we[c]                  = we;
        ch_len[c*LW +: LW]        = LW'(len);
        ch_addr[c*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        ch_wdata[c*WB +: WB]      = wd;
        for (int k = 0; k < n; k++) exp_q[c].push_back(t);
    endtask

    task automatic wait_acks(input int c, input int n, input string name);
        int got = 0;
        int cyc = 0;
        while (got < n) begin
            @(negedge clk);
            cyc++;
            if (ch_ack[c]) got++;
            if (got < n && cyc > 400 * n) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_timeout ch%0d: got %0d acks, expected %0d", name, c, got, n);
                break;
            end
        end
        @(posedge clk);
        #1;
        ch_req[c] = 1'b0;
    endtask

    task automatic do_txn(input int c, input bit we, input int len, input int addr,
                          input logic [WB-1:0] wd, input int n);
        set_fields(c, we, len, addr, wd, n);
        ch_req[c] = 1'b1;
        wait_acks(c, n, "txn");
    endtask

    task automatic rand_txn(input int c);
        int addr;
        addr = ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(0, 65535);
        do_txn(c, 1'($urandom_range(0, 1)), $urandom_range(0, 1), addr, WB'($urandom), 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    initial begin
        int start;
        int cyc;
        for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
        rom[16'h0444] = 8'hA9;
        rom[16'hFFFF] = 8'h34;
        rom[16'h0000] = 8'h12;
        reset = 1'b1; ch_req = '0; ch_we = '0; ch_len = '0; ch_addr = '0; ch_wdata = '0;
        #1;
        check("reset_ch_ack", ch_ack, 0);
        check("reset_rdata", rdata, 0);
        check("reset_bus_addr", bus_addr, 0);
        check("reset_rd_req", rd_req, 0);
        check("reset_wr_enable", wr_enable, 0);
        check("reset_wr_data", wr_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0; mem_en = 1'b1; fast_ack = 1'b1;
        @(posedge clk);
        #1;

        do_txn(0, 1'b0, 0, 16'h0444, '0, 1);
        do_txn(1, 1'b0, 1, 16'hFFFF, '0, 1);
        do_txn(0, 1'b1, 1, 16'h2000, 16'hBEEF, 1);

        // Both channels hold req for four transfers each: acks must alternate
        start = ack_log.size();
        fork
            begin set_fields(0, 1'b0, 1, 16'h0100, '0, 4); ch_req[0] = 1'b1; wait_acks(0, 4, "hold0"); end
            begin set_fields(1, 1'b1, 1, 16'h0200, 16'hCAFE, 4); ch_req[1] = 1'b1; wait_acks(1, 4, "hold1"); end
        join
        check("hold_ack_count", ack_log.size() - start, 8);
        for (int i = start + 1; i < ack_log.size(); i++)
            if (ack_log[i] == ack_log[i-1]) check("rr_alternate", ack_log[i], 1 - ack_log[i-1]);

        // Reset mid-RD_WAIT drops the transfer; the held request restarts afterwards
        mem_en = 1'b0;
        set_fields(0, 1'b0, 1, 16'h1000, '0, 1);
        ch_req[0] = 1'b1;
        cyc = 0;
        while (!rd_req && cyc < 50) begin @(negedge clk); cyc++; end
        check("rd_req_before_reset", rd_req, 1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_rd_req", rd_req, 0);
        check("midrst_bus_addr", bus_addr, 0);
        check("midrst_ch_ack", ch_ack, 0);
        check("midrst_rdata", rdata, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_en = 1'b1;
        wait_acks(0, 1, "after_reset");

        fast_ack = 1'b0;
        fork
            begin for (int k = 0; k < 15; k++) rand_txn(0); end
            begin for (int k = 0; k < 15; k++) rand_txn(1); end
        join
        repeat (4) @(posedge clk);
        check("exp_q0_drained", exp_q[0].size(), 0);
        check("exp_q1_drained", exp_q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
